// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states, error codes and defaults for the load/store unit
package lsu_pkg;

    localparam int LSU_TIMEOUT_DEF = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_REQ    = 2'b01,
        S_WAIT_R = 2'b10,
        S_DONE   = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_t;

    // Stores have no unsigned variants, so only loads accept the BU/HU codes.
    function automatic logic f3_legal(input logic lden, input logic sten, input logic [2:0] f3);
        if (lden && sten) return 1'b0;
        if (lden) return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores, alignment check and load extract/extend
module lsu_align
    import lsu_pkg::*;
#(
    parameter int CPU_WIDTH = 32
) (
    input  logic [2:0]           i_funct3,
    input  logic [1:0]           i_addr_lo,
    input  logic [CPU_WIDTH-1:0] i_rs2_data,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata,
    output logic [3:0]           o_wmask,
    output logic [CPU_WIDTH-1:0] o_wdata,
    output logic [CPU_WIDTH-1:0] o_ld_data,
    output logic                 o_misaligned
);

    logic [CPU_WIDTH-1:0] w_shift;

    assign w_shift      = i_mem_rdata >> {i_addr_lo, 3'b000};
    assign o_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));

    always_comb begin
        o_wmask = 4'b1111;
        o_wdata = i_rs2_data;
        case (i_funct3[1:0])
            2'b00: begin
                o_wmask = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rs2_data[7:0]}};
            end
            2'b01: begin
                o_wmask = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ld_data = w_shift;
        case (i_funct3)
            F3_B:    o_ld_data = {{(CPU_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_ld_data = {{(CPU_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
            F3_BU:   o_ld_data = {{(CPU_WIDTH-8){1'b0}}, w_shift[7:0]};
            F3_HU:   o_ld_data = {{(CPU_WIDTH-16){1'b0}}, w_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: request latch, memory handshake FSM, timeout and write-back
module lsu
    import lsu_pkg::*;
#(
    parameter int CPU_WIDTH   = 32,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_lsu_valid,
    input  logic                 i_idu_lden,
    input  logic                 i_idu_sten,
    input  logic [2:0]           i_idu_funct3,
    input  logic [CPU_WIDTH-1:0] i_exu_addr,
    input  logic [CPU_WIDTH-1:0] i_rs2_data,
    output logic                 o_lsu_stall,
    output logic                 o_lsu_done,
    output logic                 o_lsu_rd_wren,
    output logic [CPU_WIDTH-1:0] o_lsu_rd_data,
    output logic [1:0]           o_lsu_err,
    output logic                 o_mem_req,
    output logic                 o_mem_wen,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]           o_mem_wmask,
    input  logic                 i_mem_ready,
    input  logic                 i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_t           r_state, w_next;
    lsu_err_t             r_err, w_err;
    logic                 r_lden, r_sten;
    logic [2:0]           r_funct3;
    logic [CPU_WIDTH-1:0] r_addr, r_rs2, r_rd_data;
    logic [CW-1:0]        r_cnt;

    logic                 w_idle, w_take, w_busy, w_tmo, w_ld_cap, w_mis;
    logic [2:0]           w_f3;
    logic [1:0]           w_alo;
    logic [3:0]           w_wmask;
    logic [CPU_WIDTH-1:0] w_wdata, w_ld_data;

    assign w_idle = (r_state == S_IDLE);
    assign w_take = w_idle && i_lsu_valid && (i_idu_lden || i_idu_sten);
    assign w_busy = (r_state == S_REQ) || (r_state == S_WAIT_R);
    assign w_tmo  = (r_cnt == CW'(TIMEOUT_CYC - 1));

    // The alignment check must see the live request in IDLE; afterwards the latched copy drives lanes.
    assign w_f3  = w_idle ? i_idu_funct3 : r_funct3;
    assign w_alo = w_idle ? i_exu_addr[1:0] : r_addr[1:0];

    lsu_align #(.CPU_WIDTH(CPU_WIDTH)) u_align (
        .i_funct3     (w_f3),
        .i_addr_lo    (w_alo),
        .i_rs2_data   (r_rs2),
        .i_mem_rdata  (i_mem_rdata),
        .o_wmask      (w_wmask),
        .o_wdata      (w_wdata),
        .o_ld_data    (w_ld_data),
        .o_misaligned (w_mis)
    );

    always_comb begin
        w_next   = r_state;
        w_err    = r_err;
        w_ld_cap = 1'b0;
        case (r_state)
            S_IDLE: if (w_take) begin
                if (!f3_legal(i_idu_lden, i_idu_sten, i_idu_funct3)) begin
                    w_next = S_DONE;
                    w_err  = ERR_ILLEGAL;
                end else if (w_mis) begin
                    w_next = S_DONE;
                    w_err  = ERR_MISALIGN;
                end else begin
                    w_next = S_REQ;
                    w_err  = ERR_NONE;
                end
            end
            S_REQ: begin
                // Completion wins over a timeout landing in the same cycle.
                if (i_mem_ready && (r_sten || i_mem_rvalid)) begin
                    w_next   = S_DONE;
                    w_ld_cap = r_lden;
                end else if (w_tmo) begin
                    w_next = S_DONE;
                    w_err  = ERR_TIMEOUT;
                end else if (i_mem_ready) begin
                    w_next = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (i_mem_rvalid) begin
                    w_next   = S_DONE;
                    w_ld_cap = 1'b1;
                end else if (w_tmo) begin
                    w_next = S_DONE;
                    w_err  = ERR_TIMEOUT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_err     <= ERR_NONE;
            r_lden    <= 1'b0;
            r_sten    <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= '0;
            r_rs2     <= '0;
            r_rd_data <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err;
            if (w_take) begin
                r_lden   <= i_idu_lden;
                r_sten   <= i_idu_sten;
                r_funct3 <= i_idu_funct3;
                r_addr   <= i_exu_addr;
                r_rs2    <= i_rs2_data;
            end
            if (w_busy && ((w_next == S_REQ) || (w_next == S_WAIT_R)))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (w_ld_cap)
                r_rd_data <= w_ld_data;
        end
    end

    assign o_lsu_stall   = w_take || w_busy;
    assign o_lsu_done    = (r_state == S_DONE);
    assign o_lsu_rd_wren = o_lsu_done && r_lden && (r_err == ERR_NONE);
    assign o_lsu_rd_data = r_rd_data;
    assign o_lsu_err     = o_lsu_done ? r_err : ERR_NONE;
    assign o_mem_req     = (r_state == S_REQ);
    assign o_mem_wen     = o_mem_req && r_sten;
    assign o_mem_addr    = o_mem_req ? {r_addr[CPU_WIDTH-1:2], 2'b00} : '0;
    assign o_mem_wdata   = o_mem_wen ? w_wdata : '0;
    assign o_mem_wmask   = o_mem_wen ? w_wmask : 4'b0000;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the decode/execute datapath in the RV32E core.
- Consumes the decoded load/store enables, funct3, the ALU-computed effective address and the rs2 data.
- Performs a valid/ready transaction to data memory and returns aligned, sign- or zero-extended load data to the regfile write-back path.
- Stalls the IFU while an access is outstanding.

Parameters:
- CPU_WIDTH, 32, datapath and data-memory width.
- TIMEOUT_CYC, 255, maximum cycles spent in REQ+WAIT_R before the access aborts with a timeout error.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  synchronous, active-low reset.
- i_lsu_valid  in  1  access request qualifier from decode; sampled in IDLE only.
- i_idu_lden  in  1  load.
- i_idu_sten  in  1  store.
- i_idu_funct3  in  3  size/sign code.
- i_exu_addr  in  CPU_WIDTH  effective byte address.
- i_rs2_data  in  CPU_WIDTH  store data.
- o_lsu_stall  out  1  hold PC/IFU.
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_rd_wren  out  1  write rd this cycle (load done, no error).
- o_lsu_rd_data  out  CPU_WIDTH  extended load result.
- o_lsu_err  out  2  00 none, 01 misaligned, 10 illegal, 11 timeout; valid with o_lsu_done.
- o_mem_req  out  1  memory request valid.
- o_mem_wen  out  1  write request.
- o_mem_addr  out  CPU_WIDTH  word-aligned address {addr[31:2],2'b00}.
- o_mem_wdata  out  CPU_WIDTH  lane-replicated store data.
- o_mem_wmask  out  4  byte enables.
- i_mem_ready  in  1  memory accepts request.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  CPU_WIDTH  read data word.

Behaviour:
- Reset (i_rst==0 at a clock edge):
  - state IDLE.
  - All outputs 0, including o_mem_wmask and o_lsu_rd_data.
  - Timeout counter 0; latched request cleared.
  - Reset mid-access abandons the access. A late i_mem_rvalid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - On i_lsu_valid, latch lden, sten, funct3, addr and rs2.
  - If lden&sten, or the funct3 is illegal, go to DONE with err 10.
    - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Legal stores: 000 SB, 001 SH, 010 SW.
  - Else if misaligned (H with addr[0]==1, W with addr[1:0]!=0), go to DONE with err 01; no memory request is issued.
  - Else go to REQ.
  - i_lsu_valid with neither lden nor sten is ignored.
- REQ:
  - o_mem_req=1; address, wen, wdata and wmask are held stable until accepted.
  - On i_mem_ready:
    - Store: go to DONE.
    - Load with i_mem_rvalid in the same cycle: capture data, go to DONE.
    - Otherwise (load): go to WAIT_R.
  - o_mem_req deasserts in the cycle after acceptance.
- WAIT_R: on i_mem_rvalid, capture the extracted data and go to DONE.
- DONE:
  - o_lsu_done=1 for exactly one cycle, then IDLE.
  - o_lsu_rd_wren=1 only for an error-free load.
- Timeout:
  - Counter increments each cycle in REQ/WAIT_R and clears on leaving them.
  - On reaching TIMEOUT_CYC, go to DONE with err 11; o_lsu_rd_wren=0.
- Stall: o_lsu_stall = (IDLE & i_lsu_valid & (lden|sten)) | REQ | WAIT_R; it is low in DONE so the PC advances that cycle.
- i_lsu_valid outside IDLE is ignored.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wmask=4'b0011<<addr[1:0].
  - SW: wdata=rs2, wmask=4'b1111.
  - Loads drive wmask=0 and wen=0.
- Load extract:
  - shifted = i_mem_rdata >> (addr[1:0]*8).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW is the full word.
- o_lsu_rd_data holds its value until the next load completes.
- Minimum latency: error-free store or zero-wait load: valid at cycle N, REQ at N+1, DONE at N+2.

Decomposition:
- defines.v holds the funct3 load/store codes, LSU state encodings (2 bits), error codes and TIMEOUT default.
- One combinational sub-module, lsu_align, computes wmask, wdata lanes, the misaligned flag and the load extract/extend.
- lsu keeps the FSM, latches and counter.

Test Plan:
- SW addr=0x80000004, rs2=0xDEADBEEF, ready in first REQ cycle -> mem_addr=0x80000004, wmask=1111, wdata=0xDEADBEEF; done at N+2, rd_wren=0, err=00.
- SB addr=0x80000003, rs2=0x000000A5 -> wmask=1000, wdata=0xA5A5A5A5.
- LB addr=...2, rdata=0x00800000 with rvalid 3 cycles after ready -> rd_data=0xFFFFFF80; LBU same -> 0x00000080; stall high throughout REQ/WAIT_R.
- LH addr=...1 -> no mem_req; done at N+1, err=01, rd_wren=0. funct3=011 load -> err=10.
- i_mem_ready held 0 -> after TIMEOUT_CYC cycles done, err=11, mem_req drops.
- Reset asserted in WAIT_R, then rvalid pulsed -> state IDLE, no done, outputs 0; next LW returns correct data.
